ex_hazard_ctrl: RTL and testbench
=================================

// Module: ex_hazard_ctrl
// PURPOSE
//   Pipeline sequencer for the 16-bit five-stage core around the EX stage. Decides per cycle
//   whether each stage advances, stalls or is flushed: load-use bubbles, EX branch redirect,
//   memory-busy freeze and HLT drain. Also produces registered forwarding selects for the
//   two EX operand ports p0/p1. Sits beside the ID/EX pipeline register.
// PARAMETERS
//   REG_AW     4   register-address width (16 architectural regs, R0 hardwired 0)
//   DRAIN_CYC  3   cycles after HLT leaves ID before halted asserts (EX, MEM, WB retire)
// PORTS
//   clk          in   1       core clock, all state on rising edge
//   rst          in   1       asynchronous, active-high reset
//   id_rs        in   REG_AW  ID source reg feeding p0
//   id_rt        in   REG_AW  ID source reg feeding p1
//   id_rs_vld    in   1       id_rs actually read by ID instruction
//   id_rt_vld    in   1       id_rt actually read
//   id_hlt       in   1       ID holds HLT
//   ex_rd        in   REG_AW  EX destination
//   ex_we        in   1       EX writes ex_rd
//   ex_ld        in   1       EX instruction is LW
//   mem_rd       in   REG_AW  MEM destination
//   mem_we       in   1       MEM writes mem_rd
//   br_taken     in   1       EX resolved branch/jump taken (addResult valid)
//   mem_busy     in   1       data memory not ready this cycle
//   stall_if     out  1       hold PC and IF/ID
//   stall_id     out  1       hold ID/EX source fields
//   bubble_ex    out  1       load NOP into ID/EX
//   flush_id     out  1       load NOP into IF/ID
//   freeze_all   out  1       hold every pipeline register
//   fwd_p0_sel   out  2       registered: 0 regfile, 1 EX/MEM result, 2 MEM/WB result
//   fwd_p1_sel   out  2       same for p1
//   halted       out  1       core halted, sticky until rst
// BEHAVIOUR
//   Reset: state=RUN, all outputs 0, drain count 0. Reset mid-operation aborts drain/bubble.
//   FSM states: RUN, LDUSE, DRAIN, HALTED (2-bit encoding in package).
//   Priority per cycle, highest first: freeze > branch > load-use > HLT.
//   freeze: mem_busy=1 -> freeze_all=1 combinationally, state and fwd regs hold, all else 0.
//   branch: br_taken=1 -> flush_id=1, bubble_ex=1 that cycle; a pending LDUSE/HLT in ID is
//     discarded; state->RUN. In DRAIN, branch is ignored (HLT already past ID).
//   load-use: RUN, ex_ld=1, ex_we=1, ex_rd!=0 and matches a valid id_rs/id_rt -> stall_if=1,
//     stall_id=1, bubble_ex=1, state->LDUSE. LDUSE lasts exactly 1 cycle then RUN, no re-check.
//   forwarding (computed for ID instr, registered when ID/EX advances, held on stall/freeze,
//     cleared to 0 on bubble_ex): match vs ex_rd/ex_we -> 1, else mem_rd/mem_we -> 2, else 0;
//     R0 never forwards; EX match beats MEM match.
//   HLT: RUN, id_hlt=1, no higher event -> stall_if=1 permanently, flush_id=1, state->DRAIN,
//     count=DRAIN_CYC-1. DRAIN decrements each non-frozen cycle; at 0 -> HALTED next edge.
//   HALTED: halted=1, stall_if=1, freeze_all=1; only rst exits.
//   Outputs stall_if/stall_id/bubble_ex/flush_id are combinational from state and inputs.
// CONFIGURATION
//   HAZARD_PERF_EN defined: adds outputs stall_cnt[15:0], flush_cnt[15:0]; increment on
//   load-use stall and branch flush cycles respectively, saturate at 16'hFFFF, reset 0,
//   hold in HALTED. Undefined: ports and counters absent, behaviour otherwise identical.
// STRUCTURE
//   Package ex_hazard_pkg: state enum, fwd select constants (FWD_RF/FWD_EX/FWD_MEM), REG_AW.
//   One sub-module fwd_sel_unit (combinational match for one operand), instanced twice.
// TESTING
//   LW R3 in EX, ADD R4,R3,R1 in ID -> 1 cycle stall_if/stall_id/bubble_ex, then fwd_p0_sel=2.
//   ADD R2 in EX, SUB using R2 as rt in ID -> no stall, fwd_p1_sel=1 next edge.
//   R2 written in both EX and MEM, ID reads R2 -> fwd sel 1; ID reads R0 with ex_rd=0 -> sel 0.
//   br_taken with concurrent load-use -> flush_id=1, bubble_ex=1, stall_if=0, state RUN.
//   HLT in ID, mem_busy high 2 cycles during DRAIN -> halted asserts DRAIN_CYC+2 cycles later.
//   rst pulsed while in LDUSE and DRAIN -> all outputs 0 immediately, RUN after release.

Source files
------------

// File: rtl/ex_hazard_pkg.sv
// -----------------------------------------------------------------------------
// ex_hazard_pkg
//   Shared definitions for the EX-stage hazard controller of the 16-bit
//   five-stage core: sequencer state encoding, forwarding select codes and the
//   default register-address width.
// -----------------------------------------------------------------------------
package ex_hazard_pkg;

   // 16 architectural registers, R0 hardwired to zero
   localparam int unsigned REG_AW = 4;

   // Sequencer state encoding
   typedef logic [1:0] state_t;
   localparam state_t ST_RUN    = 2'd0;
   localparam state_t ST_LDUSE  = 2'd1;
   localparam state_t ST_DRAIN  = 2'd2;
   localparam state_t ST_HALTED = 2'd3;

   // Operand forwarding select codes
   typedef logic [1:0] fwd_sel_t;
   localparam fwd_sel_t FWD_RF  = 2'd0;  // register file read data
   localparam fwd_sel_t FWD_EX  = 2'd1;  // EX/MEM result
   localparam fwd_sel_t FWD_MEM = 2'd2;  // MEM/WB result

endpackage

// File: rtl/fwd_sel_unit.sv
// -----------------------------------------------------------------------------
// fwd_sel_unit
//   Combinational forwarding match for a single EX operand. Compares the ID
//   source register against the EX and MEM destinations and picks the
//   youngest producer. Also reports the raw EX match so the controller can
//   detect load-use hazards without a second comparator.
//
// Ports
//   i_src       ID source register address
//   i_src_vld   source is actually read by the ID instruction
//   i_ex_rd     EX destination,  i_ex_we  EX writes it
//   i_mem_rd    MEM destination, i_mem_we MEM writes it
//   o_ex_hit    live source matches the EX destination
//   o_sel       FWD_RF / FWD_EX / FWD_MEM
// -----------------------------------------------------------------------------
module fwd_sel_unit
   import ex_hazard_pkg::*;
#(
   parameter int unsigned AW = 4
) (
   input  logic [AW-1:0] i_src,
   input  logic          i_src_vld,
   input  logic [AW-1:0] i_ex_rd,
   input  logic          i_ex_we,
   input  logic [AW-1:0] i_mem_rd,
   input  logic          i_mem_we,
   output logic          o_ex_hit,
   output logic [1:0]    o_sel
);

   logic w_src_live;
   logic w_mem_hit;

   // R0 reads are constant zero, so they never take a forwarded value
   assign w_src_live = i_src_vld && (i_src != '0);
   assign o_ex_hit   = w_src_live && i_ex_we  && (i_src == i_ex_rd);
   assign w_mem_hit  = w_src_live && i_mem_we && (i_src == i_mem_rd);

   // EX holds the younger result, so it wins over MEM
   always_comb begin
      o_sel = FWD_RF;
      if (o_ex_hit) begin
         o_sel = FWD_EX;
      end else if (w_mem_hit) begin
         o_sel = FWD_MEM;
      end
   end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// ex_hazard_ctrl
//   Pipeline sequencer around the EX stage. Each cycle decides whether the
//   stages advance, stall or flush (load-use bubble, EX branch redirect,
//   memory-busy freeze, HLT drain) and registers the forwarding selects for
//   the two EX operand ports p0/p1 as the ID instruction moves into ID/EX.
//
//   Event priority, highest first: freeze > branch > load-use > HLT.
//
// Configuration
//   HAZARD_PERF_EN  when defined, adds o_stall_cnt / o_flush_cnt saturating
//                   counters of load-use stall cycles and branch flush cycles.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_id_rs / i_id_rt     ID source registers feeding p0 / p1 (+ _vld)
//   i_id_hlt              ID holds HLT
//   i_ex_rd/_we/_ld       EX destination, write enable, instruction is LW
//   i_mem_rd/_we          MEM destination, write enable
//   i_br_taken            EX resolved a taken branch/jump
//   i_mem_busy            data memory not ready
//   o_stall_if/o_stall_id hold PC+IF/ID, hold ID/EX source fields
//   o_bubble_ex           load NOP into ID/EX
//   o_flush_id            load NOP into IF/ID
//   o_freeze_all          hold every pipeline register
//   o_fwd_p0_sel/_p1_sel  registered forwarding selects
//   o_halted              core halted, sticky until reset
// -----------------------------------------------------------------------------
module ex_hazard_ctrl #(
   parameter int unsigned REG_AW    = ex_hazard_pkg::REG_AW,
   parameter int unsigned DRAIN_CYC = 3
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [REG_AW-1:0] i_id_rs,
   input  logic [REG_AW-1:0] i_id_rt,
   input  logic              i_id_rs_vld,
   input  logic              i_id_rt_vld,
   input  logic              i_id_hlt,
   input  logic [REG_AW-1:0] i_ex_rd,
   input  logic              i_ex_we,
   input  logic              i_ex_ld,
   input  logic [REG_AW-1:0] i_mem_rd,
   input  logic              i_mem_we,
   input  logic              i_br_taken,
   input  logic              i_mem_busy,
   output logic              o_stall_if,
   output logic              o_stall_id,
   output logic              o_bubble_ex,
   output logic              o_flush_id,
   output logic              o_freeze_all,
   output logic [1:0]        o_fwd_p0_sel,
   output logic [1:0]        o_fwd_p1_sel,
   output logic              o_halted
`ifdef HAZARD_PERF_EN
   ,
   output logic [15:0]       o_stall_cnt,
   output logic [15:0]       o_flush_cnt
`endif
);

   import ex_hazard_pkg::*;

   // Drain counter only has to hold DRAIN_CYC-1
   localparam int unsigned CNT_W = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYC - 1);

   state_t           r_state, w_state_d;
   logic [CNT_W-1:0] r_cnt, w_cnt_d;
   logic [1:0]       r_fwd_p0, r_fwd_p1;

   logic       w_ex_hit0, w_ex_hit1;
   logic [1:0] w_sel0, w_sel1;
   logic       w_in_run, w_in_lduse, w_in_drain, w_in_halt;
   logic       w_ldu_hit;
   logic       w_br_act, w_ldu_act, w_hlt_act;
   logic       w_adv;

   // ---------------------------------------------------------------------------
   // Operand match units
   // ---------------------------------------------------------------------------
   fwd_sel_unit #(
      .AW (REG_AW)
   ) u_fwd_p0 (
      .i_src     (i_id_rs),
      .i_src_vld (i_id_rs_vld),
      .i_ex_rd   (i_ex_rd),
      .i_ex_we   (i_ex_we),
      .i_mem_rd  (i_mem_rd),
      .i_mem_we  (i_mem_we),
      .o_ex_hit  (w_ex_hit0),
      .o_sel     (w_sel0)
   );

   fwd_sel_unit #(
      .AW (REG_AW)
   ) u_fwd_p1 (
      .i_src     (i_id_rt),
      .i_src_vld (i_id_rt_vld),
      .i_ex_rd   (i_ex_rd),
      .i_ex_we   (i_ex_we),
      .i_mem_rd  (i_mem_rd),
      .i_mem_we  (i_mem_we),
      .o_ex_hit  (w_ex_hit1),
      .o_sel     (w_sel1)
   );

   // ---------------------------------------------------------------------------
   // Event qualification
   // ---------------------------------------------------------------------------
   assign w_in_run   = (r_state == ST_RUN);
   assign w_in_lduse = (r_state == ST_LDUSE);
   assign w_in_drain = (r_state == ST_DRAIN);
   assign w_in_halt  = (r_state == ST_HALTED);

   // ex_hit already includes ex_we and excludes R0
   assign w_ldu_hit = i_ex_ld && (w_ex_hit0 || w_ex_hit1);

   // Once HLT has left ID the redirect is moot, so DRAIN/HALTED ignore branches
   assign w_br_act  = !i_mem_busy && i_br_taken && (w_in_run || w_in_lduse);
   // LDUSE is a fixed one-cycle state: the hazard is not re-evaluated there
   assign w_ldu_act = !i_mem_busy && !i_br_taken && w_in_run && w_ldu_hit;
   assign w_hlt_act = !i_mem_busy && !i_br_taken && w_in_run && !w_ldu_hit && i_id_hlt;

   // State and ID/EX-side registers move only on non-frozen, non-halted cycles
   assign w_adv = !i_mem_busy && !w_in_halt;

   // ---------------------------------------------------------------------------
   // Pipeline control outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      o_stall_if   = 1'b0;
      o_stall_id   = 1'b0;
      o_bubble_ex  = 1'b0;
      o_flush_id   = 1'b0;
      o_freeze_all = 1'b0;
      if (i_rst) begin
         // all controls quiet while reset is applied
      end else if (w_in_halt) begin
         o_stall_if   = 1'b1;
         o_freeze_all = 1'b1;
      end else if (i_mem_busy) begin
         o_freeze_all = 1'b1;
      end else if (w_br_act) begin
         o_flush_id  = 1'b1;
         o_bubble_ex = 1'b1;
      end else if (w_ldu_act) begin
         o_stall_if  = 1'b1;
         o_stall_id  = 1'b1;
         o_bubble_ex = 1'b1;
      end else if (w_hlt_act || w_in_drain) begin
         // PC stays parked and IF/ID keeps feeding NOPs behind the HLT
         o_stall_if = 1'b1;
         o_flush_id = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Sequencer
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      if (w_adv) begin
         case (r_state)
            ST_RUN: begin
               if (w_ldu_act) begin
                  w_state_d = ST_LDUSE;
               end else if (w_hlt_act) begin
                  w_state_d = ST_DRAIN;
                  w_cnt_d   = CNT_LOAD;
               end
            end
            ST_LDUSE: begin
               w_state_d = ST_RUN;
            end
            ST_DRAIN: begin
               if (r_cnt == '0) begin
                  w_state_d = ST_HALTED;
               end else begin
                  w_cnt_d = r_cnt - CNT_W'(1);
               end
            end
            default: begin
               w_state_d = r_state;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Forwarding select registers (travel with the instruction into ID/EX)
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_fwd_p0 <= FWD_RF;
         r_fwd_p1 <= FWD_RF;
      end else if (w_adv) begin
         if (o_bubble_ex) begin
            r_fwd_p0 <= FWD_RF;
            r_fwd_p1 <= FWD_RF;
         end else if (!o_stall_id) begin
            r_fwd_p0 <= w_sel0;
            r_fwd_p1 <= w_sel1;
         end
      end
   end

   assign o_fwd_p0_sel = r_fwd_p0;
   assign o_fwd_p1_sel = r_fwd_p1;
   assign o_halted     = w_in_halt;

   // ---------------------------------------------------------------------------
   // Optional performance counters
   // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
   logic [15:0] r_stall_cnt;
   logic [15:0] r_flush_cnt;

   // Events cannot occur in HALTED, so the counters hold there naturally
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_ldu_act && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
         if (w_br_act && (r_flush_cnt != 16'hFFFF)) begin
            r_flush_cnt <= r_flush_cnt + 16'd1;
         end
      end
   end

   assign o_stall_cnt = r_stall_cnt;
   assign o_flush_cnt = r_flush_cnt;
`else
   // Counters not built; control behaviour is unchanged
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ex_hazard_ctrl
//   Self-checking bench for ex_hazard_ctrl: a sequential vector table for the
//   RUN/LDUSE/freeze/branch behaviour with a forwarding-select scoreboard,
//   followed by hand-written HLT drain and asynchronous reset sequences.
// -----------------------------------------------------------------------------
module tb_ex_hazard_ctrl;

   localparam int unsigned DRAIN = 3;
   localparam logic Y = 1'b1;
   localparam logic N = 1'b0;

   logic       clk;
   logic       rst;
   logic [3:0] id_rs, id_rt, ex_rd, mem_rd;
   logic       id_rs_vld, id_rt_vld, id_hlt, ex_we, ex_ld, mem_we, br_taken, mem_busy;
   logic       stall_if, stall_id, bubble_ex, flush_id, freeze_all, halted;
   logic [1:0] fwd_p0_sel, fwd_p1_sel;
`ifdef HAZARD_PERF_EN
   logic [15:0] stall_cnt, flush_cnt;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   ex_hazard_ctrl #(
      .REG_AW    (4),
      .DRAIN_CYC (DRAIN)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_id_rs      (id_rs),
      .i_id_rt      (id_rt),
      .i_id_rs_vld  (id_rs_vld),
      .i_id_rt_vld  (id_rt_vld),
      .i_id_hlt     (id_hlt),
      .i_ex_rd      (ex_rd),
      .i_ex_we      (ex_we),
      .i_ex_ld      (ex_ld),
      .i_mem_rd     (mem_rd),
      .i_mem_we     (mem_we),
      .i_br_taken   (br_taken),
      .i_mem_busy   (mem_busy),
      .o_stall_if   (stall_if),
      .o_stall_id   (stall_id),
      .o_bubble_ex  (bubble_ex),
      .o_flush_id   (flush_id),
      .o_freeze_all (freeze_all),
      .o_fwd_p0_sel (fwd_p0_sel),
      .o_fwd_p1_sel (fwd_p1_sel),
      .o_halted     (halted)
`ifdef HAZARD_PERF_EN
      ,
      .o_stall_cnt  (stall_cnt),
      .o_flush_cnt  (flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] rs, rt;
      logic       rsv, rtv, hlt;
      logic [3:0] exrd;
      logic       exwe, exld;
      logic [3:0] memrd;
      logic       memwe, br, busy;
      logic [4:0] comb;  // {stall_if, stall_id, bubble_ex, flush_id, freeze_all}
      logic [1:0] f0, f1;
   } vec_t;

   vec_t       tv[20];
   logic [3:0] fwd_q[$];

   function automatic vec_t mk(input logic [3:0] rs, input logic [3:0] rt, input logic rsv,
                               input logic rtv, input logic hlt, input logic [3:0] exrd,
                               input logic exwe, input logic exld, input logic [3:0] memrd,
                               input logic memwe, input logic br, input logic busy,
                               input logic [4:0] comb, input logic [1:0] f0,
                               input logic [1:0] f1);
      vec_t v;
      v.rs = rs; v.rt = rt; v.rsv = rsv; v.rtv = rtv; v.hlt = hlt;
      v.exrd = exrd; v.exwe = exwe; v.exld = exld;
      v.memrd = memrd; v.memwe = memwe; v.br = br; v.busy = busy;
      v.comb = comb; v.f0 = f0; v.f1 = f1;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_idle();
      id_rs = 4'd0; id_rt = 4'd0; id_rs_vld = N; id_rt_vld = N; id_hlt = N;
      ex_rd = 4'd0; ex_we = N; ex_ld = N; mem_rd = 4'd0; mem_we = N;
      br_taken = N; mem_busy = N;
   endtask

   task automatic apply(input vec_t v);
      id_rs = v.rs; id_rt = v.rt; id_rs_vld = v.rsv; id_rt_vld = v.rtv; id_hlt = v.hlt;
      ex_rd = v.exrd; ex_we = v.exwe; ex_ld = v.exld;
      mem_rd = v.memrd; mem_we = v.memwe; br_taken = v.br; mem_busy = v.busy;
   endtask

   function automatic logic [4:0] comb_now();
      return {stall_if, stall_id, bubble_ex, flush_id, freeze_all};
   endfunction

   function automatic logic [15:0] all_now();
      return 16'({stall_if, stall_id, bubble_ex, flush_id, freeze_all, halted,
                  fwd_p0_sel, fwd_p1_sel});
   endfunction

   int   halt_edge;
   logic [3:0] exp_f;

   initial begin
      // ------------------------------------------------------------------ reset
      rst = 1'b1;
      set_idle();
      #3;
      chk("reset all outputs", all_now(), 16'h0);
      mem_busy = Y; br_taken = Y;
      #1;
      chk("reset gates freeze/branch", all_now(), 16'h0);
      set_idle();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // ------------------------------------------------------------------ table
      //           rs     rt    rsv rtv hlt exrd  we ld  memrd we br busy comb      f0    f1
      tv[0]  = mk(4'd5, 4'd2, Y, Y, N, 4'd2, Y, N, 4'd0, N, N, N, 5'b00000, 2'd0, 2'd1);
      tv[1]  = mk(4'd2, 4'd7, Y, Y, N, 4'd2, Y, N, 4'd2, Y, N, N, 5'b00000, 2'd1, 2'd0);
      tv[2]  = mk(4'd0, 4'd0, Y, Y, N, 4'd0, Y, N, 4'd0, Y, N, N, 5'b00000, 2'd0, 2'd0);
      tv[3]  = mk(4'd6, 4'd9, Y, Y, N, 4'd1, Y, N, 4'd9, Y, N, N, 5'b00000, 2'd0, 2'd2);
      tv[4]  = mk(4'd4, 4'd3, Y, Y, N, 4'd4, N, N, 4'd4, N, N, N, 5'b00000, 2'd0, 2'd0);
      tv[5]  = mk(4'd5, 4'd5, N, Y, N, 4'd5, Y, N, 4'd0, N, N, N, 5'b00000, 2'd0, 2'd1);
      // LW R3 in EX, ADD R4,R3,R1 in ID, then the load sits in MEM
      tv[6]  = mk(4'd3, 4'd1, Y, Y, N, 4'd3, Y, Y, 4'd0, N, N, N, 5'b11100, 2'd0, 2'd0);
      tv[7]  = mk(4'd3, 4'd1, Y, Y, N, 4'd0, N, N, 4'd3, Y, N, N, 5'b00000, 2'd2, 2'd0);
      // load-use through rt; LDUSE does not re-check
      tv[8]  = mk(4'd3, 4'd8, N, Y, N, 4'd8, Y, Y, 4'd0, N, N, N, 5'b11100, 2'd0, 2'd0);
      tv[9]  = mk(4'd3, 4'd8, N, Y, N, 4'd8, Y, Y, 4'd0, N, N, N, 5'b00000, 2'd0, 2'd1);
      // load to R0 is no hazard
      tv[10] = mk(4'd0, 4'd1, Y, Y, N, 4'd0, Y, Y, 4'd1, Y, N, N, 5'b00000, 2'd0, 2'd2);
      // freeze beats load-use, fwd holds
      tv[11] = mk(4'd3, 4'd0, Y, N, N, 4'd3, Y, Y, 4'd0, N, N, Y, 5'b00001, 2'd0, 2'd2);
      // branch beats load-use
      tv[12] = mk(4'd3, 4'd0, Y, N, N, 4'd3, Y, Y, 4'd0, N, Y, N, 5'b00110, 2'd0, 2'd0);
      tv[13] = mk(4'd3, 4'd0, Y, N, N, 4'd3, Y, Y, 4'd0, N, N, N, 5'b11100, 2'd0, 2'd0);
      // branch during LDUSE
      tv[14] = mk(4'd0, 4'd0, N, N, N, 4'd0, N, N, 4'd0, N, Y, N, 5'b00110, 2'd0, 2'd0);
      tv[15] = mk(4'd0, 4'd0, N, N, N, 4'd0, N, N, 4'd0, N, Y, Y, 5'b00001, 2'd0, 2'd0);
      tv[16] = mk(4'd2, 4'd2, Y, Y, N, 4'd2, Y, N, 4'd2, Y, N, N, 5'b00000, 2'd1, 2'd1);
      tv[17] = mk(4'd9, 4'd0, Y, N, N, 4'd9, Y, N, 4'd0, N, N, Y, 5'b00001, 2'd1, 2'd1);
      // branch beats HLT, then confirm still RUN
      tv[18] = mk(4'd0, 4'd0, N, N, Y, 4'd0, N, N, 4'd0, N, Y, N, 5'b00110, 2'd0, 2'd0);
      tv[19] = mk(4'd0, 4'd0, N, N, N, 4'd0, N, N, 4'd0, N, N, N, 5'b00000, 2'd0, 2'd0);

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         apply(tv[i]);
         fwd_q.push_back({tv[i].f0, tv[i].f1});
         #1;
         chk($sformatf("row%0d controls", i), 16'(comb_now()), 16'(tv[i].comb));
         @(posedge clk);
         #1;
         exp_f = fwd_q.pop_front();
         chk($sformatf("row%0d fwd sel", i), 16'({fwd_p0_sel, fwd_p1_sel}), 16'(exp_f));
      end

`ifdef HAZARD_PERF_EN
      chk("stall_cnt", stall_cnt, 16'd3);
      chk("flush_cnt", flush_cnt, 16'd3);
`endif

      // ------------------------------------------- HLT drain with 2 frozen cycles
      @(negedge clk);
      set_idle();
      id_hlt = Y; id_rs = 4'd5; id_rs_vld = Y; ex_rd = 4'd5; ex_we = Y;
      #1;
      chk("hlt controls", 16'(comb_now()), 16'(5'b10010));
      @(posedge clk);
      #1;
      chk("hlt fwd p0", 16'(fwd_p0_sel), 16'd1);
      halt_edge = 0;
      for (int e = 1; e <= 12; e++) begin
         @(negedge clk);
         set_idle();
         br_taken = (e == 1);
         mem_busy = (e == 2 || e == 3);
         #1;
         if (e == 1) chk("drain ignores branch", 16'({stall_if, bubble_ex}), 16'(2'b10));
         if (e == 2) chk("drain freeze", 16'(freeze_all), 16'd1);
         @(posedge clk);
         #1;
         if (halted) begin
            halt_edge = e;
            break;
         end
      end
      chk("halt latency", 16'(halt_edge), 16'(DRAIN + 2));
      @(negedge clk);
      br_taken = Y; ex_rd = 4'd3; ex_we = Y; ex_ld = Y; id_rs = 4'd3; id_rs_vld = Y;
      #1;
      chk("halted controls", 16'({comb_now(), halted}), 16'(6'b100011));
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("halted sticky", 16'(halted), 16'd1);

      // ---------------------------------------------------------- rst in DRAIN
      @(negedge clk);
      set_idle();
      rst = 1'b1;
      #1;
      chk("rst leaves halted", all_now(), 16'h0);
      @(negedge clk);
      rst = 1'b0;
      id_hlt = Y; id_rs = 4'd5; id_rs_vld = Y; ex_rd = 4'd5; ex_we = Y;
      @(posedge clk);
      @(negedge clk);
      set_idle();
      #1;
      chk("drain stall_if", 16'({stall_if, fwd_p0_sel}), 16'(3'b101));
      #2;
      rst = 1'b1;
      #1;
      chk("rst in drain", all_now(), 16'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("run after drain rst", 16'(comb_now()), 16'h0);
      repeat (4) @(posedge clk);
      #1;
      chk("no halt after rst", 16'(halted), 16'd0);

      // ---------------------------------------------------------- rst in LDUSE
      @(negedge clk);
      id_rs = 4'd3; id_rs_vld = Y; ex_rd = 4'd3; ex_we = Y; ex_ld = Y;
      #1;
      chk("ldu before rst", 16'(comb_now()), 16'(5'b11100));
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("lduse no recheck", 16'(comb_now()), 16'h0);
      #2;
      rst = 1'b1;
      #1;
      chk("rst in lduse", all_now(), 16'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("run after lduse rst", 16'(comb_now()), 16'(5'b11100));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
